// File: rtl/seg_name_pkg.sv
// Shared letter codes, segment patterns and the expected name sequence
// for the 7-segment name monitor.
package seg_name_pkg;

    localparam logic [3:0] L_BLANK = 4'd0;
    localparam logic [3:0] L_S     = 4'd1;
    localparam logic [3:0] L_E     = 4'd2;
    localparam logic [3:0] L_N     = 4'd3;
    localparam logic [3:0] L_O     = 4'd4;
    localparam logic [3:0] L_L     = 4'd5;
    localparam logic [3:0] L_G     = 4'd6;
    localparam logic [3:0] L_U     = 4'd7;
    localparam logic [3:0] L_UNK   = 4'd15;

    // Segment order is dp,a,b,c,d,e,f,g from bit 7 down to bit 0
    localparam logic [7:0] P_S     = 8'h5B;
    localparam logic [7:0] P_E     = 8'h4F;
    localparam logic [7:0] P_N     = 8'h15;
    localparam logic [7:0] P_O     = 8'h7E;
    localparam logic [7:0] P_L     = 8'h0E;
    localparam logic [7:0] P_G     = 8'h5F;
    localparam logic [7:0] P_U     = 8'h3E;
    localparam logic [7:0] P_BLANK = 8'h00;

    localparam int SEQ_LEN = 14;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_TRACK,
        ST_LOCK
    } mon_state_t;

    function automatic logic [3:0] exp_letter(input logic [3:0] idx);
        case (idx)
            4'd0:    return L_S;
            4'd1:    return L_E;
            4'd2:    return L_N;
            4'd3:    return L_O;
            4'd4:    return L_L;
            4'd5:    return L_G;
            4'd6:    return L_U;
            4'd7:    return L_L;
            4'd8:    return L_G;
            4'd9:    return L_O;
            4'd10:   return L_N;
            4'd11:   return L_U;
            4'd12:   return L_L;
            default: return L_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_name_monitor_if.sv
// Segment bus from the sequencer plus the monitor's result signals.
interface seg_name_monitor_if #(parameter int CNT_W = 8);
    logic             seg_stb;
    logic [7:0]       seg_in;
    logic             letter_valid;
    logic [3:0]       letter_code;
    logic [3:0]       pos;
    logic             locked;
    logic             match;
    logic             err;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output seg_stb, seg_in,
        input  letter_valid, letter_code, pos, locked, match, err, match_cnt, err_cnt
    );

    modport slave (
        input  seg_stb, seg_in,
        output letter_valid, letter_code, pos, locked, match, err, match_cnt, err_cnt
    );
endinterface

// File: rtl/seg_glyph_decode.sv
// Exact-match decode of an 8-bit segment pattern into a letter code.
module seg_glyph_decode
    import seg_name_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = L_UNK;
        case (seg)
            P_S:     code = L_S;
            P_E:     code = L_E;
            P_N:     code = L_N;
            P_O:     code = L_O;
            P_L:     code = L_L;
            P_G:     code = L_G;
            P_U:     code = L_U;
            P_BLANK: code = L_BLANK;
            default: code = L_UNK;
        endcase
    end

endmodule

// File: rtl/seg_name_monitor.sv
// Synchronises the sequencer's segment bus, samples it after a settle delay
// and tracks the decoded letters against the expected name sequence.
module seg_name_monitor
    import seg_name_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    seg_name_monitor_if.slave   bus
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    logic             stb_p0, stb_p1, stb_hist;
    logic [7:0]       seg_p0, seg_p1;
    logic [3:0]       tmr;
    logic             edge_e, cap;
    logic [3:0]       dec_code;

    mon_state_t       state, state_n;
    logic [3:0]       pos, pos_n;
    logic [3:0]       code, code_n;
    logic             locked, locked_n;
    logic             vld, vld_n;
    logic             match, match_n;
    logic             err, err_n;
    logic [CNT_W-1:0] mcnt, mcnt_n;
    logic [CNT_W-1:0] ecnt, ecnt_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    seg_glyph_decode u_decode (
        .seg  (seg_p1),
        .code (dec_code)
    );

    assign edge_e = stb_p1 & ~stb_hist;
    // A fresh edge always wins over a capture that was still pending
    assign cap    = edge_e ? (SETTLE == 1) : (tmr == 4'd1);

    // Stage p0/p1: strobe and bus synchronisers, settle timer
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_p0   <= 1'b0;
            stb_p1   <= 1'b0;
            stb_hist <= 1'b0;
            seg_p0   <= 8'h00;
            seg_p1   <= 8'h00;
            tmr      <= 4'd0;
        end else begin
            stb_p0   <= bus.seg_stb;
            stb_p1   <= stb_p0;
            stb_hist <= stb_p1;
            seg_p0   <= bus.seg_in;
            seg_p1   <= seg_p0;
            if (edge_e)
                tmr <= SETTLE_L - 4'd1;
            else if (tmr != 4'd0)
                tmr <= tmr - 4'd1;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        code_n   = code;
        locked_n = locked;
        vld_n    = 1'b0;
        match_n  = 1'b0;
        err_n    = 1'b0;
        mcnt_n   = mcnt;
        ecnt_n   = ecnt;
        if (cap) begin
            vld_n  = 1'b1;
            code_n = dec_code;
            if (state == ST_HUNT) begin
                if (dec_code == L_S) begin
                    state_n = ST_TRACK;
                    pos_n   = 4'd1;
                end else begin
                    pos_n   = 4'd0;
                end
            end else if (dec_code == exp_letter(pos)) begin
                if (pos == LAST_IDX) begin
                    pos_n    = 4'd0;
                    state_n  = ST_LOCK;
                    locked_n = 1'b1;
                    match_n  = 1'b1;
                    mcnt_n   = sat_inc(mcnt);
                end else begin
                    pos_n    = pos + 4'd1;
                end
            end else begin
                err_n    = 1'b1;
                locked_n = 1'b0;
                ecnt_n   = sat_inc(ecnt);
                if (dec_code == L_S) begin
                    state_n = ST_TRACK;
                    pos_n   = 4'd1;
                end else begin
                    state_n = ST_HUNT;
                    pos_n   = 4'd0;
                end
            end
        end
    end

    // Stage p2: registered letter result and sequence tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_HUNT;
            pos    <= 4'd0;
            code   <= 4'd0;
            locked <= 1'b0;
            vld    <= 1'b0;
            match  <= 1'b0;
            err    <= 1'b0;
            mcnt   <= '0;
            ecnt   <= '0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            code   <= code_n;
            locked <= locked_n;
            vld    <= vld_n;
            match  <= match_n;
            err    <= err_n;
            mcnt   <= mcnt_n;
            ecnt   <= ecnt_n;
        end
    end

    assign bus.letter_valid = vld;
    assign bus.letter_code  = code;
    assign bus.pos          = pos;
    assign bus.locked       = locked;
    assign bus.match        = match;
    assign bus.err          = err;
    assign bus.match_cnt    = mcnt;
    assign bus.err_cnt      = ecnt;

endmodule

// File: tb/tb_seg_name_monitor.sv
// Directed bench for seg_name_monitor: a reference tracker queues the expected
// result of every strobe and a monitor pops and compares each letter_valid.
module tb_seg_name_monitor;

    localparam int SETTLE_TB = 4;
    localparam int CNT_TB    = 2;

    typedef struct {
        logic [3:0]        code;
        logic [3:0]        pos;
        logic              locked;
        logic              match;
        logic              err;
        logic [CNT_TB-1:0] mcnt;
        logic [CNT_TB-1:0] ecnt;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] PAT  [14] = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E,
                              8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E, 8'h00};
    int         EXPC [14] = '{1, 2, 3, 4, 5, 6, 7, 5, 6, 4, 3, 7, 5, 0};

    bit                m_track;
    int                m_pos;
    logic              m_locked;
    logic [CNT_TB-1:0] m_mcnt;
    logic [CNT_TB-1:0] m_ecnt;

    seg_name_monitor_if #(.CNT_W(CNT_TB)) bus ();

    seg_name_monitor #(.SETTLE(SETTLE_TB), .CNT_W(CNT_TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_track  = 1'b0;
        m_pos    = 0;
        m_locked = 1'b0;
        m_mcnt   = '0;
        m_ecnt   = '0;
    endtask

    // Reference tracker: applies one letter and queues the result the DUT must show
    task automatic push_exp(input int code, input int ecyc);
        exp_t e;
        e.match = 1'b0;
        e.err   = 1'b0;
        if (!m_track) begin
            if (code == 1) begin
                m_track = 1'b1;
                m_pos   = 1;
            end else begin
                m_pos = 0;
            end
        end else if (code == EXPC[m_pos]) begin
            if (m_pos == 13) begin
                m_pos    = 0;
                m_locked = 1'b1;
                e.match  = 1'b1;
                if (m_mcnt != {CNT_TB{1'b1}}) m_mcnt = m_mcnt + 1'b1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            e.err    = 1'b1;
            m_locked = 1'b0;
            if (m_ecnt != {CNT_TB{1'b1}}) m_ecnt = m_ecnt + 1'b1;
            if (code == 1) begin
                m_pos = 1;
            end else begin
                m_track = 1'b0;
                m_pos   = 0;
            end
        end
        e.code   = 4'(code);
        e.pos    = 4'(m_pos);
        e.locked = m_locked;
        e.mcnt   = m_mcnt;
        e.ecnt   = m_ecnt;
        e.cyc    = ecyc;
        sb.push_back(e);
    endtask

    // Two sync flops to the edge cycle, then SETTLE cycles to the registered result
    task automatic present(input logic [7:0] p, input int code);
        @(negedge clk);
        bus.seg_in  = p;
        bus.seg_stb = 1'b1;
        push_exp(code, cyc + 2 + SETTLE_TB);
        repeat (3) @(negedge clk);
        bus.seg_stb = 1'b0;
        repeat (SETTLE_TB + 4) @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_locked"}, 32'(bus.locked), 32'(m_locked));
        chk({tag, "_pos"}, 32'(bus.pos), 32'(m_pos));
        chk({tag, "_mcnt"}, 32'(bus.match_cnt), 32'(m_mcnt));
        chk({tag, "_ecnt"}, 32'(bus.err_cnt), 32'(m_ecnt));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.letter_valid), 32'd0);
        chk({tag, "_code"}, 32'(bus.letter_code), 32'd0);
        chk({tag, "_pos"}, 32'(bus.pos), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
        chk({tag, "_match"}, 32'(bus.match), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_mcnt"}, 32'(bus.match_cnt), 32'd0);
        chk({tag, "_ecnt"}, 32'(bus.err_cnt), 32'd0);
    endtask

    initial begin
        bus.seg_stb = 1'b0;
        bus.seg_in  = 8'h00;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (bus.letter_valid) begin
                        chk("sb_entry_present", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            mon_e = sb.pop_front();
                            chk("lv_cycle", 32'(cyc), 32'(mon_e.cyc));
                            chk("lv_code", 32'(bus.letter_code), 32'(mon_e.code));
                            chk("lv_pos", 32'(bus.pos), 32'(mon_e.pos));
                            chk("lv_locked", 32'(bus.locked), 32'(mon_e.locked));
                            chk("lv_match", 32'(bus.match), 32'(mon_e.match));
                            chk("lv_err", 32'(bus.err), 32'(mon_e.err));
                            chk("lv_mcnt", 32'(bus.match_cnt), 32'(mon_e.mcnt));
                            chk("lv_ecnt", 32'(bus.err_cnt), 32'(mon_e.ecnt));
                        end
                    end else begin
                        chk("idle_no_pulse", 32'({bus.match, bus.err}), 32'd0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        // Clean full sequence
        for (int i = 0; i < 14; i++) present(PAT[i], EXPC[i]);
        chk("t1_locked", 32'(bus.locked), 32'd1);
        chk("t1_mcnt", 32'(bus.match_cnt), 32'd1);
        chk("t1_ecnt", 32'(bus.err_cnt), 32'd0);
        chk("t1_pos", 32'(bus.pos), 32'd0);
        chk_state("t1");

        // Enter mid-stream after a reset-free hunt
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 4; i < 14; i++) present(PAT[i], EXPC[i]);
        chk("t2_hunt_ecnt", 32'(bus.err_cnt), 32'd0);
        chk("t2_hunt_pos", 32'(bus.pos), 32'd0);
        for (int i = 0; i < 14; i++) present(PAT[i], EXPC[i]);
        chk("t2_locked", 32'(bus.locked), 32'd1);
        chk("t2_mcnt", 32'(bus.match_cnt), 32'd1);
        chk_state("t2");

        // Wrong letter while locked, then a restart on S
        for (int i = 0; i < 3; i++) present(PAT[i], EXPC[i]);
        present(8'h4F, 2);
        chk("t3_ecnt", 32'(bus.err_cnt), 32'd1);
        chk("t3_locked", 32'(bus.locked), 32'd0);
        chk("t3_pos", 32'(bus.pos), 32'd0);
        for (int i = 0; i < 3; i++) present(PAT[i], EXPC[i]);
        present(8'h5B, 1);
        chk("t3_s_pos", 32'(bus.pos), 32'd1);
        chk("t3_s_ecnt", 32'(bus.err_cnt), 32'd2);
        for (int i = 1; i < 14; i++) present(PAT[i], EXPC[i]);
        chk_state("t3");

        // Two edges SETTLE-2 cycles apart: only the second is captured
        @(negedge clk);
        bus.seg_in  = 8'hFF;
        bus.seg_stb = 1'b1;
        @(negedge clk);
        bus.seg_stb = 1'b0;
        @(negedge clk);
        bus.seg_in  = PAT[0];
        bus.seg_stb = 1'b1;
        push_exp(EXPC[0], cyc + 2 + SETTLE_TB);
        repeat (3) @(negedge clk);
        bus.seg_stb = 1'b0;
        repeat (SETTLE_TB + 4) @(negedge clk);
        chk_state("t4");

        // Reset during a pending capture at pos 7
        for (int i = 1; i < 7; i++) present(PAT[i], EXPC[i]);
        chk("t5_pre_pos", 32'(bus.pos), 32'd7);
        @(negedge clk);
        bus.seg_in  = PAT[7];
        bus.seg_stb = 1'b1;
        @(negedge clk);
        bus.seg_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_all_zero("t5_rst");
        repeat (SETTLE_TB + 8) @(negedge clk);
        chk("t5_no_pending", 32'(bus.letter_valid), 32'd0);
        present(PAT[0], EXPC[0]);
        chk("t5_restart_pos", 32'(bus.pos), 32'd1);
        for (int i = 1; i < 14; i++) present(PAT[i], EXPC[i]);
        chk_state("t5");

        // Counter saturation and an unknown pattern
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 14; i++) present(PAT[i], EXPC[i]);
            chk("t6_mcnt", 32'(bus.match_cnt), 32'(m_mcnt));
        end
        chk("t6_mcnt_sat", 32'(bus.match_cnt), 32'd3);
        present(8'hFF, 15);
        chk_state("t6");

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_name_monitor.md
Name: seg_name_monitor

Overview:
- Receive-side companion to the 7-segment name sequencer.
- Watches the sequencer's segment bus and its advance strobe (the same push-button), and decodes each displayed 8-bit pattern into a 4-bit letter code.
- Checks the decoded letters against the expected cyclic sequence S E n O L G U L G O n U L <blank>, and reports per-letter results, sequence lock, completed-sequence and error events.
- Used on-chip as a self-check and on the bench as a scoreboard front end.

Parameters:
- SETTLE, 4, clk cycles between the detected strobe edge and sampling of seg_in; allowed range 1..15.
- CNT_W, 8, width of the saturating match and error counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seg_stb  in  1  asynchronous advance strobe; the sequencer updates seg_in on its rising edge
- seg_in  in  8  segment bus: bit7=dp, bit6..0 = a,b,c,d,e,f,g
- letter_valid  out  1  one-cycle pulse; letter_code is new
- letter_code  out  4  decoded glyph: 0 blank, 1 S, 2 E, 3 n, 4 O, 5 L, 6 G, 7 U, 15 unknown
- pos  out  4  next expected sequence index, 0..13
- locked  out  1  set after one full correct sequence; cleared on error
- match  out  1  one-cycle pulse when index 13 (blank) is accepted
- err  out  1  one-cycle pulse on a mismatch while tracking
- match_cnt  out  CNT_W  saturating count of match pulses
- err_cnt  out  CNT_W  saturating count of err pulses

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0, FSM=HUNT, synchronisers and timer are cleared.
- Synchronisers:
  - seg_stb passes through a 2-flop synchroniser plus a history flop.
  - Edge E is the cycle in which sync=1 and history=0.
  - seg_in passes through a 2-flop synchroniser on all 8 bits.
- Settle timer:
  - In cycle E, timer loads SETTLE.
  - The timer decrements each cycle and the synchronised seg_in is sampled when it reaches 1, i.e. cycle E+SETTLE-1.
  - The decoded result is registered; letter_valid, letter_code, pos, match and err all update together in cycle E+SETTLE.
  - A new edge while the timer is running reloads the timer; the earlier capture is abandoned (last edge wins) and no letter_valid is produced for it.
- Decode:
  - Exact 8-bit compare against the patterns: S=0x5B, E=0x4F, n=0x15, O=0x7E, L=0x0E, G=0x5F, U=0x3E, blank=0x00.
  - Anything else, including dp=1, decodes to 15.
- Expected sequence EXP[0..13] = 1,2,3,4,5,6,7,5,6,4,3,7,5,0.
- FSM (evaluated only on a captured letter):
  - HUNT: code==1 → TRACK, pos=1. Otherwise stay in HUNT with pos=0 and no err.
  - TRACK/LOCK, code==EXP[pos]: pos=pos+1; at pos==13, accept → pos=0, match pulse, match_cnt+1, state LOCK, locked=1.
  - TRACK/LOCK, mismatch: err pulse, err_cnt+1, locked=0. If code==1 → TRACK, pos=1; else → HUNT, pos=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- match and err are never asserted in the same cycle.
- rst asserted mid-capture or mid-sequence discards all state; no pulses are generated in the cycle after reset.

Decomposition:
- Package seg_name_pkg holds:
  - letter code constants (L_BLANK..L_U, L_UNK);
  - segment pattern constants;
  - SEQ_LEN=14;
  - a function exp_letter(idx) returning EXP[idx].
- One combinational sub-module, seg_glyph_decode: 8-bit pattern → 4-bit code.
- Synchronisers, timer, FSM and counters stay in the top module.

Test Plan:
- Reset, then 14 clean strobes with seg_in stepping through the correct patterns, each held at least SETTLE+3 cycles:
  - 14 letter_valid pulses with codes 1,2,3,4,5,6,7,5,6,4,3,7,5,0;
  - match pulses once on the 14th; locked=1, match_cnt=1, err_cnt=0, pos=0.
- Start the stream at index 4 (L):
  - no err while hunting;
  - lock-in at the next S;
  - match after 14 further letters.
- While locked, present 0x4F where O is expected:
  - err pulse, err_cnt=1, locked=0, pos=0, HUNT.
  - If S is presented instead, pos=1 in TRACK.
- Two strobe edges SETTLE-2 cycles apart:
  - exactly one letter_valid, SETTLE cycles after the second edge;
  - it decodes the pattern present at that time.
- Assert rst for one cycle mid-sequence (pos=7) during a running settle timer:
  - all outputs 0, no letter_valid for the pending capture;
  - the next S restarts tracking.
- With CNT_W=2, run 5 full sequences: match_cnt saturates at 3. Present 0xFF: letter_code=15.
